// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - age-ordered reservation station and issue queue
// Optional RS_WAKEUP_BYPASS_EN: same-cycle wakeup broadcast feeds selection and payload.
module rs_issue_queue #(
  parameter int ENTRIES = 16,
  parameter int DISP_W  = 2,
  parameter int ISSUE_W = 3,
  parameter int WB_W    = 3,
  parameter int PREG_W  = 7,
  parameter int DATA_W  = 32,
  parameter int ROB_W   = 4,
  parameter int CTRL_W  = 8,
  localparam int FU_W   = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1,
  localparam int CNT_W  = $clog2(ENTRIES) + 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic [DISP_W-1:0]          i_disp_valid,
  output logic                       o_disp_ready,
  input  logic [DISP_W*PREG_W-1:0]   i_disp_src0_preg,
  input  logic [DISP_W*PREG_W-1:0]   i_disp_src1_preg,
  input  logic [DISP_W-1:0]          i_disp_src0_rdy,
  input  logic [DISP_W-1:0]          i_disp_src1_rdy,
  input  logic [DISP_W*DATA_W-1:0]   i_disp_src0_data,
  input  logic [DISP_W*DATA_W-1:0]   i_disp_src1_data,
  input  logic [DISP_W*PREG_W-1:0]   i_disp_dst_preg,
  input  logic [DISP_W*DATA_W-1:0]   i_disp_imm,
  input  logic [DISP_W*CTRL_W-1:0]   i_disp_ctrl,
  input  logic [DISP_W*FU_W-1:0]     i_disp_fu,
  input  logic [DISP_W*ROB_W-1:0]    i_disp_rob,
  input  logic [WB_W-1:0]            i_wb_valid,
  input  logic [WB_W*PREG_W-1:0]     i_wb_preg,
  input  logic [WB_W*DATA_W-1:0]     i_wb_data,
  input  logic [ISSUE_W-1:0]         i_fu_ready,
  output logic [ISSUE_W-1:0]         o_issue_valid,
  output logic [ISSUE_W*DATA_W-1:0]  o_issue_src0,
  output logic [ISSUE_W*DATA_W-1:0]  o_issue_src1,
  output logic [ISSUE_W*DATA_W-1:0]  o_issue_imm,
  output logic [ISSUE_W*PREG_W-1:0]  o_issue_dst_preg,
  output logic [ISSUE_W*CTRL_W-1:0]  o_issue_ctrl,
  output logic [ISSUE_W*ROB_W-1:0]   o_issue_rob,
  output logic [CNT_W-1:0]           o_count
);
  localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int LANE_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;

  typedef logic [DATA_W:0] hit_data_t;  // {hit, data}

  logic [ENTRIES-1:0] valid_q, s0_rdy_q, s1_rdy_q;
  logic [PREG_W-1:0]  s0_preg_q [ENTRIES];
  logic [PREG_W-1:0]  s1_preg_q [ENTRIES];
  logic [DATA_W-1:0]  s0_data_q [ENTRIES];
  logic [DATA_W-1:0]  s1_data_q [ENTRIES];
  logic [DATA_W-1:0]  imm_q     [ENTRIES];
  logic [PREG_W-1:0]  dst_q     [ENTRIES];
  logic [CTRL_W-1:0]  ctrl_q    [ENTRIES];
  logic [FU_W-1:0]    fu_q      [ENTRIES];
  logic [ROB_W-1:0]   rob_q     [ENTRIES];
  logic [ENTRIES-1:0] age_q     [ENTRIES];  // age_q[i][j]: entry i is older than entry j
  logic [CNT_W-1:0]   count_q;

  function automatic hit_data_t wb_lookup(input logic [PREG_W-1:0] tag);
    hit_data_t r;
    r = '0;
    for (int b = WB_W - 1; b >= 0; b--)
      if (i_wb_valid[b] && i_wb_preg[b*PREG_W +: PREG_W] == tag)
        r = {1'b1, i_wb_data[b*DATA_W +: DATA_W]};
    return r;
  endfunction

  function automatic hit_data_t resolve(input logic [PREG_W-1:0] tag, input logic rdy,
                                        input logic [DATA_W-1:0] prf);
    hit_data_t w;
    w = wb_lookup(tag);
    if (tag == '0) return {1'b1, {DATA_W{1'b0}}};
    if (w[DATA_W]) return w;
    return {rdy, prf};
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [ENTRIES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < ENTRIES; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  assign o_disp_ready = (count_q <= CNT_W'(ENTRIES - DISP_W));
  assign o_count      = count_q;

  hit_data_t wake0 [ENTRIES];
  hit_data_t wake1 [ENTRIES];
  hit_data_t disp0 [DISP_W];
  hit_data_t disp1 [DISP_W];

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      wake0[i] = wb_lookup(s0_preg_q[i]);
      wake1[i] = wb_lookup(s1_preg_q[i]);
    end
    for (int k = 0; k < DISP_W; k++) begin
      disp0[k] = resolve(i_disp_src0_preg[k*PREG_W +: PREG_W], i_disp_src0_rdy[k],
                         i_disp_src0_data[k*DATA_W +: DATA_W]);
      disp1[k] = resolve(i_disp_src1_preg[k*PREG_W +: PREG_W], i_disp_src1_rdy[k],
                         i_disp_src1_data[k*DATA_W +: DATA_W]);
    end
  end

  // Lanes take the lowest free slots in ascending order; freed-this-cycle slots are not yet free.
  logic [ENTRIES-1:0] alloc_mask;
  logic [LANE_W-1:0]  alloc_lane [ENTRIES];
  logic               placed;

  always_comb begin
    alloc_mask = '0;
    placed     = 1'b0;
    for (int i = 0; i < ENTRIES; i++) alloc_lane[i] = '0;
    if (o_disp_ready && !i_flush) begin
      for (int k = 0; k < DISP_W; k++) begin
        placed = !i_disp_valid[k];
        for (int i = 0; i < ENTRIES; i++) begin
          if (!placed && !valid_q[i] && !alloc_mask[i]) begin
            placed        = 1'b1;
            alloc_mask[i] = 1'b1;
            alloc_lane[i] = LANE_W'(k);
          end
        end
      end
    end
  end

  logic [ENTRIES-1:0] s0_ok, s1_ok;
  logic [DATA_W-1:0]  s0_val [ENTRIES];
  logic [DATA_W-1:0]  s1_val [ENTRIES];

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      s0_ok[i]  = s0_rdy_q[i];
      s1_ok[i]  = s1_rdy_q[i];
      s0_val[i] = s0_data_q[i];
      s1_val[i] = s1_data_q[i];
`ifdef RS_WAKEUP_BYPASS_EN
      if (!s0_rdy_q[i]) {s0_ok[i], s0_val[i]} = wake0[i];
      if (!s1_rdy_q[i]) {s1_ok[i], s1_val[i]} = wake1[i];
`endif
    end
  end

  logic [ENTRIES-1:0] cand [ISSUE_W];
  logic [ENTRIES-1:0] pick [ISSUE_W];
  logic [ISSUE_W-1:0] issue_go;
  logic [IDX_W-1:0]   issue_idx [ISSUE_W];
  logic [ENTRIES-1:0] issue_free;

  always_comb begin
    issue_go   = '0;
    issue_free = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      issue_idx[p] = '0;
      for (int i = 0; i < ENTRIES; i++)
        cand[p][i] = valid_q[i] && (fu_q[i] == FU_W'(p)) && s0_ok[i] && s1_ok[i] && i_fu_ready[p];
      for (int i = 0; i < ENTRIES; i++) begin
        pick[p][i] = cand[p][i];
        for (int j = 0; j < ENTRIES; j++)
          if (j != i && cand[p][j] && age_q[j][i]) pick[p][i] = 1'b0;
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (pick[p][i]) begin
          issue_go[p]  = 1'b1;
          issue_idx[p] = IDX_W'(i);
        end
      end
      issue_free = issue_free | pick[p];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q          <= '0;
      count_q          <= '0;
      o_issue_valid    <= '0;
      o_issue_src0     <= '0;
      o_issue_src1     <= '0;
      o_issue_imm      <= '0;
      o_issue_dst_preg <= '0;
      o_issue_ctrl     <= '0;
      o_issue_rob      <= '0;
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= '0;
    end else if (i_flush) begin
      valid_q       <= '0;
      count_q       <= '0;
      o_issue_valid <= '0;
    end else begin
      o_issue_valid <= issue_go;
      count_q       <= count_q + popcount(alloc_mask) - popcount(issue_free);
      for (int p = 0; p < ISSUE_W; p++) begin
        if (issue_go[p]) begin
          o_issue_src0[p*DATA_W +: DATA_W]     <= s0_val[issue_idx[p]];
          o_issue_src1[p*DATA_W +: DATA_W]     <= s1_val[issue_idx[p]];
          o_issue_imm[p*DATA_W +: DATA_W]      <= imm_q[issue_idx[p]];
          o_issue_dst_preg[p*PREG_W +: PREG_W] <= dst_q[issue_idx[p]];
          o_issue_ctrl[p*CTRL_W +: CTRL_W]     <= ctrl_q[issue_idx[p]];
          o_issue_rob[p*ROB_W +: ROB_W]        <= rob_q[issue_idx[p]];
        end
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (issue_free[i]) valid_q[i] <= 1'b0;
        if (alloc_mask[i]) begin
          valid_q[i]   <= 1'b1;
          s0_preg_q[i] <= i_disp_src0_preg[alloc_lane[i]*PREG_W +: PREG_W];
          s1_preg_q[i] <= i_disp_src1_preg[alloc_lane[i]*PREG_W +: PREG_W];
          s0_rdy_q[i]  <= disp0[alloc_lane[i]][DATA_W];
          s1_rdy_q[i]  <= disp1[alloc_lane[i]][DATA_W];
          s0_data_q[i] <= disp0[alloc_lane[i]][DATA_W-1:0];
          s1_data_q[i] <= disp1[alloc_lane[i]][DATA_W-1:0];
          imm_q[i]     <= i_disp_imm[alloc_lane[i]*DATA_W +: DATA_W];
          dst_q[i]     <= i_disp_dst_preg[alloc_lane[i]*PREG_W +: PREG_W];
          ctrl_q[i]    <= i_disp_ctrl[alloc_lane[i]*CTRL_W +: CTRL_W];
          fu_q[i]      <= i_disp_fu[alloc_lane[i]*FU_W +: FU_W];
          rob_q[i]     <= i_disp_rob[alloc_lane[i]*ROB_W +: ROB_W];
        end else if (valid_q[i]) begin
          if (!s0_rdy_q[i] && wake0[i][DATA_W]) begin
            s0_rdy_q[i]  <= 1'b1;
            s0_data_q[i] <= wake0[i][DATA_W-1:0];
          end
          if (!s1_rdy_q[i] && wake1[i][DATA_W]) begin
            s1_rdy_q[i]  <= 1'b1;
            s1_data_q[i] <= wake1[i][DATA_W-1:0];
          end
        end
        // A new entry is younger than everything already queued and than earlier lanes.
        for (int j = 0; j < ENTRIES; j++) begin
          if (alloc_mask[i])
            age_q[i][j] <= alloc_mask[j] && (alloc_lane[j] > alloc_lane[i]);
          else if (alloc_mask[j])
            age_q[i][j] <= 1'b1;
        end
      end
    end
  end
endmodule
